// File: rtl/muldiv_hilo_if.sv
// Bus between the control/regfile side and the multiply/divide unit.
//   start, op, operandA, operandB, mthi, mtlo : requests from the control unit
//   readHi, readLo                            : HI/LO register contents
//   busy, done, divByZero                     : completion handshake
interface muldiv_hilo_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] readHi;
  logic [WIDTH-1:0] readLo;
  logic             busy;
  logic             done;
  logic             divByZero;

  modport master (
    output start, op, operandA, operandB, mthi, mtlo,
    input  readHi, readLo, busy, done, divByZero
  );

  modport slave (
    input  start, op, operandA, operandB, mthi, mtlo,
    output readHi, readLo, busy, done, divByZero
  );
endinterface

// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One shift-add (multiply) or restoring-subtract (divide) step per clock,
// then a FIX cycle that applies sign correction and writes HI/LO.
// Latency is WIDTH+1 cycles from the accepting edge to valid HI/LO.
//
// Ports:
//   clock     : rising-edge clock
//   reset     : asynchronous active-low reset
//   bus       : muldiv_hilo_if.slave (start/op/operands/mthi/mtlo in,
//               readHi/readLo/busy/done/divByZero out, all registered)
//
// Build option:
//   MULDIV_SIGNED_EN : when defined, op[0]=1 selects signed mult/div.
//                      When undefined, op[0] is ignored and all ops are unsigned.
module muldiv_hilo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clock,
  input  logic          reset,
  muldiv_hilo_if.slave  bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [2*WIDTH-1:0] acc, acc_nxt;      // MUL: {partial hi, multiplier}; DIV: {rem, quo}
  logic [WIDTH-1:0]   opnd, opnd_nxt;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_raw, a_raw_nxt;  // unmodified dividend for divide-by-zero result
  logic               is_div, is_div_nxt;
  logic [WIDTH-1:0]   hi, hi_nxt;
  logic [WIDTH-1:0]   lo, lo_nxt;
  logic               busy, busy_nxt;
  logic               done, done_nxt;
  logic               dbz, dbz_nxt;

  logic [WIDTH-1:0]   mag_a_c, mag_b_c;
  logic [WIDTH:0]     mul_sum_c;
  logic [WIDTH:0]     div_shift_c;
  logic [WIDTH:0]     div_diff_c;
  logic [WIDTH-1:0]   fix_hi_c, fix_lo_c;
  logic               fix_dbz_c;
  logic               accept_c;

  assign accept_c = (state == IDLE) && bus.start;

`ifdef MULDIV_SIGNED_EN
  logic sign_a_c, sign_b_c;
  logic neg_q, neg_r;

  // Signed ops run on magnitudes; signs are remembered for FIX.
  always_comb begin
    sign_a_c = bus.op[0] & bus.operandA[WIDTH-1];
    sign_b_c = bus.op[0] & bus.operandB[WIDTH-1];
    mag_a_c  = sign_a_c ? -bus.operandA : bus.operandA;
    mag_b_c  = sign_b_c ? -bus.operandB : bus.operandB;
  end

  // neg_q: result (product/quotient) negative; neg_r: remainder follows dividend.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept_c) begin
      neg_q <= sign_a_c ^ sign_b_c;
      neg_r <= sign_a_c;
    end
  end
`else
  logic unused_op0;
  assign unused_op0 = bus.op[0];
  assign mag_a_c    = bus.operandA;
  assign mag_b_c    = bus.operandB;
`endif

  // Single-step datapath for both iterative algorithms.
  always_comb begin
    mul_sum_c   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    div_shift_c = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff_c  = div_shift_c - {1'b0, opnd};
  end

  // Final result selection for the FIX cycle.
  always_comb begin
    fix_hi_c  = acc[2*WIDTH-1:WIDTH];
    fix_lo_c  = acc[WIDTH-1:0];
    fix_dbz_c = 1'b0;
`ifdef MULDIV_SIGNED_EN
    if (!is_div) begin
      if (neg_q) {fix_hi_c, fix_lo_c} = -acc;
    end else begin
      if (neg_q) fix_lo_c = -acc[WIDTH-1:0];
      if (neg_r) fix_hi_c = -acc[2*WIDTH-1:WIDTH];
    end
`endif
    // Divide by zero overrides any sign handling.
    if (is_div && (opnd == '0)) begin
      fix_hi_c  = a_raw;
      fix_lo_c  = '1;
      fix_dbz_c = 1'b1;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    acc_nxt    = acc;
    opnd_nxt   = opnd;
    a_raw_nxt  = a_raw;
    is_div_nxt = is_div;
    hi_nxt     = hi;
    lo_nxt     = lo;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    dbz_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          is_div_nxt = bus.op[1];
          a_raw_nxt  = bus.operandA;
          cnt_nxt    = '0;
          busy_nxt   = 1'b1;
          if (bus.op[1]) begin
            state_nxt = DIV;
            acc_nxt   = {{WIDTH{1'b0}}, mag_a_c};
            opnd_nxt  = mag_b_c;
          end else begin
            state_nxt = MUL;
            acc_nxt   = {{WIDTH{1'b0}}, mag_b_c};
            opnd_nxt  = mag_a_c;
          end
        end else begin
          if (bus.mthi) hi_nxt = bus.operandA;
          if (bus.mtlo) lo_nxt = bus.operandA;
        end
      end

      MUL: begin
        if (acc[0]) acc_nxt = {mul_sum_c, acc[WIDTH-1:1]};
        else        acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
        cnt_nxt = cnt + CW'(1);
        if (cnt == LAST) state_nxt = FIX;
      end

      DIV: begin
        // A clear borrow bit means the trial subtraction fits.
        if (!div_diff_c[WIDTH]) acc_nxt = {div_diff_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else                    acc_nxt = {div_shift_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        cnt_nxt = cnt + CW'(1);
        if (cnt == LAST) state_nxt = FIX;
      end

      FIX: begin
        hi_nxt    = fix_hi_c;
        lo_nxt    = fix_lo_c;
        dbz_nxt   = fix_dbz_c;
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      acc    <= acc_nxt;
      opnd   <= opnd_nxt;
      a_raw  <= a_raw_nxt;
      is_div <= is_div_nxt;
      hi     <= hi_nxt;
      lo     <= lo_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      dbz    <= dbz_nxt;
    end
  end

  assign bus.readHi    = hi;
  assign bus.readLo    = lo;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.divByZero = dbz;

endmodule

// File: doc/muldiv_hilo.md
# muldiv_hilo

Iterative multiply/divide unit with HI/LO result registers. It sits directly downstream of the register file read ports: `readData1`/`readData2` feed `operandA`/`operandB`. `readHi`/`readLo` return to the writeback mux for `mfhi`/`mflo`. It runs one shift-add or restore-subtract step per clock and reports completion with a busy/done handshake so the control unit can stall.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: begin an operation; sampled only while `busy`=0.
- `op` in 2: operation select. 00 = multu, 01 = mult, 10 = divu, 11 = div.
- `operandA` in WIDTH: multiplicand/dividend, from `readData1`; also the source for `mthi`/`mtlo`.
- `operandB` in WIDTH: multiplier/divisor, from `readData2`.
- `mthi` in 1: load HI from `operandA`.
- `mtlo` in 1: load LO from `operandA`.
- `readHi` out WIDTH: HI register (product upper half / remainder).
- `readLo` out WIDTH: LO register (product lower half / quotient).
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse when HI/LO receive a new result.
- `divByZero` out 1: valid while `done`=1; set when a divide had `operandB`=0.

## Operation
- **Reset values:** FSM in IDLE; `readHi`=0, `readLo`=0, `busy`=0, `done`=0, `divByZero`=0. Reset mid-operation aborts the operation and discards all partial state.
- **States:** IDLE, MUL, DIV, FIX.
  - IDLE → MUL on `start` with `op[1]`=0.
  - IDLE → DIV on `start` with `op[1]`=1.
  - MUL/DIV → FIX after exactly `WIDTH` iteration cycles.
  - FIX → IDLE unconditionally.
- **Operand capture:** `operandA`, `operandB`, and `op` are captured on the accepting edge. Later changes to the inputs have no effect on the running operation.
- **MUL:** radix-2 shift-add on unsigned magnitudes, producing a 2·WIDTH-bit accumulator.
- **DIV:** restoring division on unsigned magnitudes, giving quotient and remainder.
- **FIX (sign correction for signed ops):**
  - Product is negated when the operand signs differ.
  - Quotient is negated when the signs differ.
  - Remainder takes the sign of the dividend.
- **FIX (writeback):** HI/LO are written and `done` is pulsed.
  - Multiply: HI = product[2W-1:W], LO = product[W-1:0].
  - Divide: HI = remainder, LO = quotient.
- **Divide by zero:** runs with the same latency and sets `divByZero`=1. Result is HI = `operandA`, LO = all ones, for both `divu` and `div`; no sign correction is applied.
- **Signed overflow** (`div`, −2^(W−1) / −1): LO = 0x80000000, HI = 0 (for W=32). `divByZero`=0.
- **`mthi`/`mtlo`:** take effect only in IDLE with `start`=0. HI/LO are loaded at the next edge; both may be asserted together. They are ignored while `busy`=1 or when `start`=1 in the same cycle (`start` has priority).
- **Ignored inputs:** `start` while `busy`=1 is ignored and not queued. HI/LO hold their previous values throughout an operation until FIX.

## Timing
- Edge N: `start` is accepted. `busy`=1 from the cycle after edge N.
- Edges N+1 … N+WIDTH: iteration steps.
- Edge N+WIDTH+1: FIX executes. From the cycle after this edge, HI/LO hold the new result, `done`=1 and `busy`=0.
- Latency is WIDTH+1 cycles from the accepting edge to valid results, i.e. 33 cycles for W=32.
- `done` stays high for exactly one cycle. A new `start` may be accepted in the same cycle `done` is high (back-to-back operation).
- `mthi`/`mtlo` have a one-cycle latency.
- `busy` and `readHi`/`readLo` are register outputs with no combinational path from the inputs.

## Configuration
- **`MULDIV_SIGNED_EN` defined:** `op` 01 and 11 perform signed `mult`/`div` with FIX sign correction as described above.
- **`MULDIV_SIGNED_EN` undefined:** `op[0]` is ignored. All operations are unsigned, the sign-correction logic is omitted, and the FIX cycle is still present so latency is unchanged.

## Test plan
- **Reset:** reset low mid-MUL (cycle 10) → next cycle `busy`=0, `readHi`=`readLo`=0, `done` never pulses.
- **multu:** 0xFFFFFFFF × 0xFFFFFFFF → after 33 cycles HI=0xFFFFFFFE, LO=0x00000001, one-cycle `done`.
- **mult (signed build):** −7 × 3 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- **div (signed build):**
  - −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- **divu by zero:** 100 / 0 → HI=100, LO=0xFFFFFFFF, `divByZero`=1 with `done`.
- **Handshake:**
  - `start` and `mthi` asserted while busy → both ignored.
  - `mtlo` with operandA=0x1234 in IDLE → LO=0x1234 next cycle.
  - Back-to-back `start` on the `done` cycle is accepted.
